// File: rtl/cordic_phase_nco_if.sv
// Bus bundle between the phase NCO, its controller and the mode-1 CORDIC pipeline.
// master drives control and CORDIC results; slave is the NCO itself.
interface cordic_phase_nco_if #(
  parameter int unsigned WIDTH = 15,
  parameter int unsigned ACC_W = 24
);
  logic                    run;
  logic                    phase_clr;
  logic                    freq_load;
  logic [ACC_W-1:0]        freq_word;
  logic [2*WIDTH-1:0]      operand;
  logic                    op_valid;
  logic [2*WIDTH-1:0]      results;
  logic signed [WIDTH-1:0] sin_out;
  logic signed [WIDTH-1:0] cos_out;
  logic                    out_valid;

  modport master (
    output run, phase_clr, freq_load, freq_word, results,
    input  operand, op_valid, sin_out, cos_out, out_valid
  );

  modport slave (
    input  run, phase_clr, freq_load, freq_word, results,
    output operand, op_valid, sin_out, cos_out, out_valid
  );
endinterface

// File: rtl/cordic_phase_nco.sv
// Phase-accumulator NCO driving a sin/cos CORDIC with a Q3.12 angle folded into +/-pi/2,
// plus the matching cos sign correction on the returning results.
module cordic_phase_nco #(
  parameter int unsigned WIDTH     = 15,
  parameter int unsigned ACC_W     = 24,
  parameter int unsigned ALIGN_DLY = 13
) (
  input logic               clk,
  input logic               rst_n,
  cordic_phase_nco_if.slave bus
);

  localparam logic signed [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] MaxVal = ~MinVal;

  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [ACC_W-1:0]        fw_q, fw_d;
  logic signed [16:0]      t_a_q, t_a_d;
  logic                    cneg_a_q, cneg_a_d;
  logic                    vld_a_q, vld_a_d;
  logic [WIDTH-1:0]        angle_q, angle_d;
  logic                    op_valid_q;
  logic                    cneg_b_q;
  logic [ALIGN_DLY-1:0]    dvld_q, dvld_d;
  logic [ALIGN_DLY-1:0]    dcneg_q, dcneg_d;
  logic signed [WIDTH-1:0] sin_q, sin_d;
  logic signed [WIDTH-1:0] cos_q, cos_d;
  logic                    out_valid_q, out_valid_d;

  logic signed [16:0]      s_ext;
  logic signed [16:0]      t_fold;
  logic                    cneg_fold;
  logic signed [31:0]      prod;
  logic signed [WIDTH-1:0] cos_in;
  logic signed [WIDTH-1:0] cos_neg;

  // Top 16 accumulator bits are the phase in 2^-16 turn; fold the outer half-circle back.
  always_comb begin
    s_ext     = {acc_q[ACC_W-1], acc_q[ACC_W-1 -: 16]};
    t_fold    = s_ext;
    cneg_fold = 1'b0;
    if (s_ext > 17'sd16384) begin
      t_fold    = 17'sd32768 - s_ext;
      cneg_fold = 1'b1;
    end else if (s_ext < -17'sd16384) begin
      t_fold    = -17'sd32768 - s_ext;
      cneg_fold = 1'b1;
    end
  end

  always_comb begin
    fw_d     = bus.freq_load ? bus.freq_word : fw_q;
    acc_d    = acc_q;
    t_a_d    = t_a_q;
    cneg_a_d = cneg_a_q;
    vld_a_d  = 1'b0;
    if (bus.phase_clr) begin
      acc_d = '0;
    end else if (bus.run) begin
      acc_d    = acc_q + fw_q;
      t_a_d    = t_fold;
      cneg_a_d = cneg_fold;
      vld_a_d  = 1'b1;
    end
  end

  // 25736 = round(2*pi*2^12) turns 2^-16 turn units into Q3.12 radians, rounded half up.
  always_comb begin
    prod    = 32'(t_a_q) * 32'sd25736 + 32'sd32768;
    angle_d = WIDTH'(prod >>> 16);
  end

  // Sideband tracks the free-running CORDIC, so it shifts every cycle.
  always_comb begin
    dvld_d  = {dvld_q[ALIGN_DLY-2:0], op_valid_q};
    dcneg_d = {dcneg_q[ALIGN_DLY-2:0], cneg_b_q};
  end

  always_comb begin
    cos_in      = bus.results[2*WIDTH-1:WIDTH];
    cos_neg     = (cos_in == MinVal) ? MaxVal : -cos_in;
    sin_d       = sin_q;
    cos_d       = cos_q;
    out_valid_d = dvld_q[ALIGN_DLY-1];
    if (dvld_q[ALIGN_DLY-1]) begin
      sin_d = bus.results[WIDTH-1:0];
      cos_d = dcneg_q[ALIGN_DLY-1] ? cos_neg : cos_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      fw_q        <= '0;
      t_a_q       <= '0;
      cneg_a_q    <= 1'b0;
      vld_a_q     <= 1'b0;
      angle_q     <= '0;
      op_valid_q  <= 1'b0;
      cneg_b_q    <= 1'b0;
      dvld_q      <= '0;
      dcneg_q     <= '0;
      sin_q       <= '0;
      cos_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      fw_q        <= fw_d;
      t_a_q       <= t_a_d;
      cneg_a_q    <= cneg_a_d;
      vld_a_q     <= vld_a_d;
      angle_q     <= angle_d;
      op_valid_q  <= vld_a_q;
      cneg_b_q    <= cneg_a_q;
      dvld_q      <= dvld_d;
      dcneg_q     <= dcneg_d;
      sin_q       <= sin_d;
      cos_q       <= cos_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.operand   = {{WIDTH{1'b0}}, angle_q};
  assign bus.op_valid  = op_valid_q;
  assign bus.sin_out   = sin_q;
  assign bus.cos_out   = cos_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_cordic_phase_nco.sv
// Bench for cordic_phase_nco: a stand-in 13-stage CORDIC returns a simple known function of
// the angle; an accumulator model fills operand/output scoreboards checked with cycle timing.
module tb_cordic_phase_nco;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cordic_phase_nco_if #(.WIDTH(15), .ACC_W(24)) bus ();

  cordic_phase_nco #(.WIDTH(15), .ACC_W(24), .ALIGN_DLY(13)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Stand-in CORDIC: sin = 2a, cos = a - 9950 (1000 at a = 0), latency 13 edges.
  function automatic int sin_f(input int a);
    return 2 * a;
  endfunction

  function automatic int cos_f(input int a);
    return (a == 0) ? 1000 : a - 9950;
  endfunction

  logic signed [14:0] pipe [13];
  always @(posedge clk) begin
    pipe[0] <= bus.operand[14:0];
    for (int i = 1; i < 13; i++) pipe[i] <= pipe[i-1];
  end

  int tail_a;
  assign tail_a = int'(pipe[12]);
  assign bus.results = {15'(cos_f(tail_a)), 15'(sin_f(tail_a))};

  // Quadrant-based reference for fold + scaling, from the unsigned 16-bit phase.
  function automatic void fold_model(input logic [23:0] acc, output int a, output bit c);
    int     p;
    int     t;
    longint prod;
    p = int'(acc[23:8]);
    if (p <= 16384) begin
      t = p;         c = 1'b0;
    end else if (p < 49152) begin
      t = 32768 - p; c = 1'b1;
    end else begin
      t = p - 65536; c = 1'b0;
    end
    prod = longint'(t) * 25736 + 32768;
    a = int'(prod >>> 16);
  endfunction

  typedef struct packed { int due; int a; } op_t;
  typedef struct packed { int due; int s; int c; } out_t;

  op_t  op_q[$];
  out_t out_q[$];
  int   op_log[$];
  int   cos_log[$];
  int   sin_log[$];
  int   last_s = 0;
  int   last_c = 0;
  logic [23:0] m_acc = '0;
  logic [23:0] m_fw = '0;
  op_t  oe;
  out_t ue;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.op_valid) begin
        total++;
        if (op_q.size() == 0) begin
          bad++;
          $display("FAIL op_unexpected: op_valid=1 at cycle %0d, required 0", cyc);
        end else begin
          oe = op_q.pop_front();
          if (oe.due != cyc || bus.operand !== {15'b0, 15'(oe.a)}) begin
            bad++;
            $display("FAIL operand: got %0d at cycle %0d (upper=%h), required %0d at cycle %0d",
                     $signed(bus.operand[14:0]), cyc, bus.operand[29:15], oe.a, oe.due);
          end
        end
        op_log.push_back(int'($signed(bus.operand[14:0])));
      end else if (op_q.size() > 0 && op_q[0].due <= cyc) begin
        total++; bad++;
        $display("FAIL op_missing: op_valid=0 at cycle %0d, required 1", cyc);
        void'(op_q.pop_front());
      end
      if (bus.out_valid) begin
        total++;
        if (out_q.size() == 0) begin
          bad++;
          $display("FAIL out_unexpected: out_valid=1 at cycle %0d, required 0", cyc);
        end else begin
          ue = out_q.pop_front();
          last_s = ue.s;
          last_c = ue.c;
          if (ue.due != cyc || int'(bus.sin_out) != ue.s || int'(bus.cos_out) != ue.c) begin
            bad++;
            $display("FAIL out: got sin=%0d cos=%0d at cycle %0d, required sin=%0d cos=%0d at %0d",
                     bus.sin_out, bus.cos_out, cyc, ue.s, ue.c, ue.due);
          end
        end
        sin_log.push_back(int'(bus.sin_out));
        cos_log.push_back(int'(bus.cos_out));
      end else if (out_q.size() > 0 && out_q[0].due <= cyc) begin
        total++; bad++;
        $display("FAIL out_missing: out_valid=0 at cycle %0d, required 1", cyc);
        void'(out_q.pop_front());
      end
    end
  end

  // One cycle of stimulus, starting and ending just after a falling edge.
  task automatic step(input bit r, input bit c, input bit l, input logic [23:0] w);
    int a;
    bit cn;
    int cf;
    int ec;
    bus.run = r; bus.phase_clr = c; bus.freq_load = l; bus.freq_word = w;
    if (c) begin
      m_acc = '0;
    end else if (r) begin
      fold_model(m_acc, a, cn);
      cf = cos_f(a);
      ec = cn ? ((cf == -16384) ? 16383 : -cf) : cf;
      op_q.push_back('{due: cyc + 2, a: a});
      out_q.push_back('{due: cyc + 16, s: sin_f(a), c: ec});
      m_acc = m_acc + m_fw;
    end
    if (l) m_fw = w;
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    step(1'b0, 1'b0, 1'b0, '0);
    while ((op_q.size() > 0 || out_q.size() > 0) && n < 40) begin
      step(1'b0, 1'b0, 1'b0, '0);
      n++;
    end
    total++;
    if (op_q.size() > 0 || out_q.size() > 0) begin
      bad++;
      $display("FAIL drain: %0d operands and %0d outputs outstanding, required 0",
               op_q.size(), out_q.size());
    end
  endtask

  task automatic clear_logs();
    op_log.delete(); sin_log.delete(); cos_log.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    total++;
    if (bus.operand !== '0 || bus.op_valid !== 1'b0 || bus.sin_out !== '0 ||
        bus.cos_out !== '0 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s: operand=%h op_valid=%b sin=%0d cos=%0d out_valid=%b, required all 0",
               tag, bus.operand, bus.op_valid, bus.sin_out, bus.cos_out, bus.out_valid);
    end
  endtask

  task automatic check_log(input string tag, input int idx, input int got_sz, input int got,
                           input int exp);
    total++;
    if (idx >= got_sz || got != exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %0d (log size %0d), required %0d", tag, idx, got, got_sz, exp);
    end
  endtask

  task automatic test_reset();
    bus.run = 0; bus.phase_clr = 0; bus.freq_load = 0; bus.freq_word = '0;
    #1;
    check_outputs_zero("reset_initial");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b1, 24'h100000);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, '0);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("reset_midstream");
    op_q.delete(); out_q.delete();
    m_acc = '0; m_fw = '0;
    @(negedge clk); @(negedge clk);
    check_outputs_zero("reset_held");
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b1, 24'h100000);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, '0);
    drain();
  endtask

  task automatic test_sweep();
    int ea[7] = '{0, 1609, 3217, 4826, 6434, 4826, 3217};
    clear_logs();
    step(1'b0, 1'b1, 1'b1, 24'h100000);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, '0);
    drain();
    for (int i = 0; i < 7; i++)
      check_log("sweep_angle", i, op_log.size(), (i < op_log.size()) ? op_log[i] : -99999, ea[i]);
    check_log("sweep_cos", 5, cos_log.size(), (cos_log.size() > 5) ? cos_log[5] : -99999, 5124);
    check_log("sweep_cos", 6, cos_log.size(), (cos_log.size() > 6) ? cos_log[6] : -99999, 6733);
  endtask

  task automatic test_boundary();
    int ea[8] = '{0, 6434, 0, -6434, 0, 0, 0, -6434};
    int ec[8] = '{1000, -3516, -1000, -16384, 1000, -1000, 1000, 16383};
    clear_logs();
    step(1'b0, 1'b1, 1'b1, 24'h400000);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b1, 24'h7FFFFF);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b1, 24'hBFFF00);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, '0);
    drain();
    for (int i = 0; i < 8; i++) begin
      check_log("bound_angle", i, op_log.size(), (i < op_log.size()) ? op_log[i] : -99999, ea[i]);
      check_log("bound_cos", i, cos_log.size(), (i < cos_log.size()) ? cos_log[i] : -99999, ec[i]);
    end
    check_log("bound_sin", 7, sin_log.size(), (sin_log.size() > 7) ? sin_log[7] : -99999, -12868);
  endtask

  task automatic test_control();
    int ea[4] = '{0, 1609, 3217, 0};
    clear_logs();
    step(1'b0, 1'b1, 1'b1, 24'h100000);
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    drain();
    for (int i = 0; i < 4; i++)
      check_log("ctrl_angle", i, op_log.size(), (i < op_log.size()) ? op_log[i] : -99999, ea[i]);
    step(1'b0, 1'b0, 1'b0, '0);
    total++;
    if (bus.out_valid !== 1'b0 || int'(bus.sin_out) != last_s || int'(bus.cos_out) != last_c) begin
      bad++;
      $display("FAIL ctrl_hold: out_valid=%b sin=%0d cos=%0d, required 0 %0d %0d",
               bus.out_valid, bus.sin_out, bus.cos_out, last_s, last_c);
    end
  endtask

  task automatic test_freq_load();
    int ea[3] = '{0, 1609, 4826};
    clear_logs();
    step(1'b0, 1'b1, 1'b1, 24'h100000);
    step(1'b1, 1'b0, 1'b1, 24'h200000);
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    drain();
    for (int i = 0; i < 3; i++)
      check_log("fload_angle", i, op_log.size(), (i < op_log.size()) ? op_log[i] : -99999, ea[i]);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 200; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
           24'($urandom));
    drain();
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_boundary();
    test_control();
    test_freq_load();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench still running at %0t, required completion", $time);
    $fatal(1, "timeout");
  end

endmodule
